// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (request-to-send, odd parity, ack check).
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int REQ_CYCLES     = 50,
   parameter int START_TIMEOUT  = 750000,
   parameter int XFER_TIMEOUT   = 100000
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic [7:0] iDATA,
   input  logic       iSTART,
   output logic       oBUSY,
   output logic       oDONE,
   output logic       oERROR,
   input  logic       PS2_CLK_IN,
   input  logic       PS2_DAT_IN,
   output logic       PS2_CLK_OE,
   output logic       PS2_DAT_OE
);

   typedef enum logic [3:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_WAIT_CLK, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
   } state_e;

   localparam logic [19:0] INH_LAST   = 20'(INHIBIT_CYCLES - 1);
   localparam logic [19:0] REQ_LAST   = 20'(REQ_CYCLES - 1);
   localparam logic [19:0] START_LAST = 20'(START_TIMEOUT - 1);
   localparam logic [19:0] XFER_LAST  = 20'(XFER_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [10:0] shift_q, shift_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [19:0] timer_q, timer_d;
   logic        clk_meta_q, clk_sync_q, clk_prev_q;
   logic        dat_meta_q, dat_sync_q;
   logic        clk_oe_d, dat_oe_d, busy_d, done_d, err_d;
   logic        fall;
   logic        xfer_expired;

   assign fall         = clk_prev_q & ~clk_sync_q;
   assign xfer_expired = (timer_q >= XFER_LAST);

   // Synchronizers reset high (idle bus level) so reset release never fakes a falling edge.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         timer_q    <= '0;
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
         PS2_CLK_OE <= 1'b0;
         PS2_DAT_OE <= 1'b0;
         oBUSY      <= 1'b0;
         oDONE      <= 1'b0;
         oERROR     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         timer_q    <= timer_d;
         clk_meta_q <= PS2_CLK_IN;
         clk_sync_q <= clk_meta_q;
         clk_prev_q <= clk_sync_q;
         dat_meta_q <= PS2_DAT_IN;
         dat_sync_q <= dat_meta_q;
         PS2_CLK_OE <= clk_oe_d;
         PS2_DAT_OE <= dat_oe_d;
         oBUSY      <= busy_d;
         oDONE      <= done_d;
         oERROR     <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      timer_d = (timer_q == 20'hFFFFF) ? timer_q : timer_q + 20'd1;
      case (state_q)
         S_IDLE: begin
            timer_d = timer_q;
            if (iSTART) begin
               shift_d = {1'b1, ~^iDATA, iDATA, 1'b0};
               cnt_d   = '0;
               timer_d = '0;
               state_d = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (timer_q >= INH_LAST) begin
               timer_d = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (timer_q >= REQ_LAST) begin
               timer_d = '0;
               state_d = S_WAIT_CLK;
            end
         end
         S_WAIT_CLK: begin
            if (fall) begin
               shift_d = {1'b0, shift_q[10:1]};
               cnt_d   = 4'd1;
               timer_d = '0;
               state_d = S_SEND;
            end else if (timer_q >= START_LAST) begin
               state_d = S_ERR;
            end
         end
         S_SEND: begin
            if (fall) begin
               shift_d = {1'b0, shift_q[10:1]};
               cnt_d   = cnt_q + 4'd1;
               if (cnt_q == 4'd9) state_d = S_ACK;
            end else if (xfer_expired) begin
               state_d = S_ERR;
            end
         end
         S_ACK: begin
            if (fall)              state_d = dat_sync_q ? S_ERR : S_WAIT_IDLE;
            else if (xfer_expired) state_d = S_ERR;
         end
         S_WAIT_IDLE: begin
            if (clk_sync_q && dat_sync_q) state_d = S_DONE;
            else if (xfer_expired)        state_d = S_ERR;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every pad enable and flag is a flop.
   always_comb begin
      clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
      dat_oe_d = 1'b0;
      if (state_d == S_REQ)                               dat_oe_d = 1'b1;
      else if (state_d == S_WAIT_CLK || state_d == S_SEND) dat_oe_d = ~shift_d[0];
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      err_d  = (state_d == S_ERR);
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;

   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data_i;
   logic       start_i;
   logic       busy, done_o, err_o;
   logic       clk_oe, dat_oe;
   logic       dev_clk, dev_dat;
   wire        clk_pad = ~clk_oe & dev_clk;
   wire        dat_pad = ~dat_oe & dev_dat;

   int n_tests = 0;
   int n_fail  = 0;

   int  cyc = 0, done_tot = 0, err_tot = 0, bad_tot = 0, inh_tot = 0, req_tot = 0;
   int  rel_cyc = 0, err_cyc = 0;
   logic prev_pulse = 1'b0, prev_clk_oe = 1'b0;

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES(20), .REQ_CYCLES(4), .START_TIMEOUT(400), .XFER_TIMEOUT(2000)
   ) dut (
      .iCLK(clk), .iRST_N(rst_n), .iDATA(data_i), .iSTART(start_i),
      .oBUSY(busy), .oDONE(done_o), .oERROR(err_o),
      .PS2_CLK_IN(clk_pad), .PS2_DAT_IN(dat_pad),
      .PS2_CLK_OE(clk_oe), .PS2_DAT_OE(dat_oe)
   );

   // Observes pulse shape and phase lengths on the falling edge, away from the active edge.
   always @(negedge clk) begin
      cyc++;
      if (done_o) done_tot++;
      if (err_o) begin err_tot++; err_cyc = cyc; end
      if (done_o && err_o) bad_tot++;
      if ((done_o || err_o) && !busy) bad_tot++;
      if (prev_pulse && (done_o || err_o || busy)) bad_tot++;
      prev_pulse = done_o || err_o;
      if (busy && clk_oe && !dat_oe) inh_tot++;
      if (busy && clk_oe && dat_oe) req_tot++;
      if (prev_clk_oe && !clk_oe && busy) rel_cyc = cyc;
      prev_clk_oe = clk_oe;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference frame from the protocol rules: start 0, data LSB first, odd parity, stop 1.
   function automatic logic [10:0] ref_frame(input logic [7:0] d);
      int ones = 0;
      logic par;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      par = (ones % 2 == 0);
      return 11'(1 << 10) | (11'(par) << 9) | (11'(d) << 1);
   endfunction

   task automatic dev_xfer(input logic ack_val, input int max_falls,
                           output logic [10:0] cap, output logic ok);
      ok  = 1'b0;
      cap = '0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (busy && !clk_oe && dat_oe) ok = 1'b1;
      end
      if (!ok) return;
      repeat (10) @(negedge clk);
      cap[0] = dat_pad;
      for (int k = 1; k <= 10 && k <= max_falls; k++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         dev_clk = 1'b1;
         cap[k] = dat_pad;
         if (k < 10) repeat (HALF) @(negedge clk);
      end
      if (max_falls < 11) return;
      repeat (HALF / 2) @(negedge clk);
      dev_dat = ack_val;
      repeat (HALF / 2) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (5) @(negedge clk);
      dev_dat = 1'b1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      chk({name, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic pulse_start(input logic [7:0] d);
      @(negedge clk);
      data_i  = d;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      data_i  = ~d;
   endtask

   task automatic do_send(input string name, input logic [7:0] d, input logic ack,
                          input logic inject, input logic [10:0] exp_frame,
                          input int exp_done, input int exp_err);
      int s_done = done_tot, s_err = err_tot, s_bad = bad_tot, s_inh = inh_tot, s_req = req_tot;
      logic [10:0] cap;
      logic ok;
      pulse_start(d);
      chk({name, "_busy_accept"}, 32'(busy), 32'd1);
      chk({name, "_clkoe_accept"}, 32'(clk_oe), 32'd1);
      fork
         dev_xfer(ack, 11, cap, ok);
         begin
            if (inject) begin
               repeat (250) @(negedge clk);
               chk({name, "_busy_at_inject"}, 32'(busy), 32'd1);
               data_i  = 8'h55;
               start_i = 1'b1;
               @(negedge clk);
               start_i = 1'b0;
            end
         end
      join
      wait_idle(name, 3000);
      chk({name, "_req_seen"}, 32'(ok), 32'd1);
      chk({name, "_frame"}, 32'(cap), 32'(exp_frame));
      chk({name, "_done"}, 32'(done_tot - s_done), 32'(exp_done));
      chk({name, "_error"}, 32'(err_tot - s_err), 32'(exp_err));
      chk({name, "_pulse_shape"}, 32'(bad_tot - s_bad), 32'd0);
      chk({name, "_inhibit_len"}, 32'(inh_tot - s_inh), 32'd20);
      chk({name, "_req_len"}, 32'(req_tot - s_req), 32'd4);
      chk({name, "_pads_released"}, 32'({clk_oe, dat_oe}), 32'd0);
   endtask

   typedef struct {
      logic [7:0]  d;
      logic        ack;
      logic [10:0] frame;
      int          done_n;
      int          err_n;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int s_done, s_err, diff;
      logic [10:0] cap;
      logic ok;
      logic [7:0] rd;
      logic rack;

      vecs[0] = '{8'hED, 1'b0, 11'h7DA, 1, 0};
      vecs[1] = '{8'h07, 1'b0, 11'h40E, 1, 0};
      vecs[2] = '{8'h00, 1'b0, 11'h600, 1, 0};
      vecs[3] = '{8'hFF, 1'b0, 11'h7FE, 1, 0};
      vecs[4] = '{8'hED, 1'b1, 11'h7DA, 0, 1};

      rst_n = 1'b0; start_i = 1'b0; data_i = 8'h00; dev_clk = 1'b1; dev_dat = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({busy, done_o, err_o, clk_oe, dat_oe}), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_reset_outputs", 32'({busy, done_o, err_o, clk_oe, dat_oe}), 32'd0);

      for (int i = 0; i < 5; i++)
         do_send($sformatf("vec%0d", i), vecs[i].d, vecs[i].ack, 1'b0,
                 vecs[i].frame, vecs[i].done_n, vecs[i].err_n);

      for (int i = 0; i < 6; i++) begin
         rd   = 8'($urandom_range(0, 255));
         rack = ($urandom_range(0, 3) == 0);
         do_send($sformatf("rnd%0d", i), rd, rack, 1'b0, ref_frame(rd),
                 rack ? 0 : 1, rack ? 1 : 0);
      end

      do_send("inject", 8'hC3, 1'b0, 1'b1, ref_frame(8'hC3), 1, 0);

      s_done = done_tot; s_err = err_tot;
      pulse_start(8'h12);
      wait_idle("no_clock", 1000);
      diff = err_cyc - rel_cyc;
      chk("no_clock_error", 32'(err_tot - s_err), 32'd1);
      chk("no_clock_done", 32'(done_tot - s_done), 32'd0);
      chk("no_clock_window", 32'(diff >= 399 && diff <= 401), 32'd1);
      chk("no_clock_dat_oe", 32'(dat_oe), 32'd0);

      s_done = done_tot; s_err = err_tot;
      pulse_start(8'hA5);
      dev_xfer(1'b0, 4, cap, ok);
      chk("rst_req_seen", 32'(ok), 32'd1);
      chk("rst_partial_frame", 32'(cap[3:0]), 32'(ref_frame(8'hA5) & 11'h00F));
      repeat (5) @(negedge clk);
      chk("rst_pre_busy", 32'(busy), 32'd1);
      chk("rst_pre_dat_oe", 32'(dat_oe), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_pads", 32'({clk_oe, dat_oe}), 32'd0);
      chk("rst_async_busy", 32'(busy), 32'd0);
      dev_clk = 1'b1; dev_dat = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_no_pulse", 32'((done_tot - s_done) + (err_tot - s_err)), 32'd0);
      do_send("after_reset", 8'hF4, 1'b0, 1'b0, 11'h5E8, 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
